program_sequencer: RTL

- Upstream instruction feeder for the 16-bit bus processor.
- Holds a small loadable program store and presents one instruction word at a time on din, with a one-cycle run pulse.
- Supplies the immediate word for two-word instructions.
- Waits for the processor's done pulse before issuing the next instruction.
- Stops on a HALT opcode.

---
 rtl/program_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Instruction feeder for the 16-bit bus processor: loadable program store, one-word issue with run strobe.
// Optional watchdog on the processor handshake is enabled by defining PROGRAM_SEQUENCER_WATCHDOG_EN.
module program_sequencer #(
    parameter int          DEPTH   = 16,
    parameter int          AW      = 4,
    parameter logic [3:0]  MVI_OP  = 4'h1,
    parameter logic [3:0]  HALT_OP = 4'hF,
    parameter int          TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic          start,
    input  logic          proc_done,
    output logic [15:0]   din,
    output logic          run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALTED
    } state_t;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t        state, state_next;
    logic [AW-1:0] pc_r, pc_next;
    logic [15:0]   mem [DEPTH];
    logic [15:0]   cur_word, prev_word;
    logic [3:0]    cur_op;

    assign cur_word  = mem[pc_r];
    assign prev_word = mem[pc_r - PC_ONE];
    assign cur_op    = cur_word[15:12];
    assign pc        = pc_r;
    assign busy      = (state == S_ISSUE) || (state == S_IMM) || (state == S_WAIT);
    assign halted    = (state == S_HALTED);

    // NOTE: the program store has no reset so a reset never wipes a loaded program.
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt;
    logic          err_r;
    logic          accept_start;
    logic          wd_expired;

    assign accept_start = start && ((state == S_IDLE) || (state == S_HALTED));
    assign wd_expired   = (state == S_WAIT) && !proc_done && (wd_cnt == CW'(TIMEOUT - 1));
    assign err          = err_r;

    // Counter sits at zero outside WAIT, so every entry into WAIT starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_r  <= 1'b0;
        end else begin
            if (state != S_WAIT) begin
                wd_cnt <= '0;
            end else if (!proc_done) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (accept_start) begin
                err_r <= 1'b0;
            end else if (wd_expired) begin
                err_r <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc_r  <= '0;
        end else begin
            state <= state_next;
            pc_r  <= pc_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc_r;
        unique case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cur_op == HALT_OP) begin
                    state_next = S_HALTED;
                end else begin
                    pc_next    = pc_r + PC_ONE;
                    state_next = (cur_op == MVI_OP) ? S_IMM : S_WAIT;
                end
            end
            S_IMM: begin
                pc_next    = pc_r + PC_ONE;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (proc_done) begin
                    state_next = S_ISSUE;
                end
`ifdef PROGRAM_SEQUENCER_WATCHDOG_EN
                else if (wd_expired) begin
                    state_next = S_HALTED;
                end
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    // In WAIT the store cannot change, so the previous address still holds the word last presented.
    always_comb begin
        din = 16'h0000;
        run = 1'b0;
        unique case (state)
            S_ISSUE: begin
                din = cur_word;
                run = (cur_op != HALT_OP);
            end
            S_IMM:   din = cur_word;
            S_WAIT:  din = prev_word;
            default: din = 16'h0000;
        endcase
    end

endmodule
